// File: rtl/range_pkg.sv
// range_pkg
//   Shared definitions for the range-finder stream source.
//   - state_t          : playback FSM states (IDLE, PLAY, FLUSH)
//   - DEF_WIDTH/DEPTH  : default sample width and buffer capacity
//   - ptr_width()      : address width for a buffer of a given depth
package range_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Address width of the sample buffer; a depth of 1 still gets one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/range_sample_buf.sv
// range_sample_buf
//   Register file holding the captured samples.
//   Ports:
//     clock  in   rising-edge clock
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address
//     rdata  out  read data (combinational, so playback has no read latency)
//   Contents are not reset; they are only meaningful below the owner's count.
module range_sample_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/range_stream_gen.sv
// range_stream_gen
//   On-chip stimulus player for the range finder: samples are appended
//   through a write port while idle, and a start replays them one per clock
//   framed by go (first sample) and finish (last sample), followed by a
//   one-cycle settle (FLUSH) and a done pulse.
//   Ports:
//     clock, reset       clock and asynchronous active-high reset
//     wr_en, wr_data     append a sample (IDLE only)
//     clear              empty the buffer, clear sticky flags (IDLE only)
//     start              begin playback (IDLE only)
//     data_out, go, finish  sample stream and framing
//     busy, done, error  status; done/error are one-cycle pulses
//     count, overflow    fill level and sticky dropped-write flag
//     range_in, mismatch optional expected-range check
//   Optional feature macro: RANGE_EXPECT_EN -- tracks min/max of the written
//   samples and compares range_in against max-min during FLUSH. Without it
//   mismatch is tied low and range_in is ignored.
module range_stream_gen
  import range_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clear,
  input  logic                   start,
  output logic [WIDTH-1:0]       data_out,
  output logic                   go,
  output logic                   finish,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   error,
  input  logic [WIDTH-1:0]       range_in,
  output logic                   mismatch
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_data_out;
  logic             r_go;
  logic             r_finish;
  logic             r_busy;
  logic             r_done;
  logic             r_overflow;
  logic             r_error;
  // Marks that FLUSH just ended, so done lands in the following IDLE cycle.
  logic             r_flush_q;

  logic             w_full;
  logic             w_wr_ok;
  logic             w_last;
  logic [CW-1:0]    w_cnt_idle;
  logic [WIDTH-1:0] w_rdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_wr_ok = (r_state == IDLE) && wr_en && !clear && !w_full;
  assign w_last  = ({1'b0, r_rd_ptr} == (r_count - CW'(1)));

  // Count after this cycle's IDLE write/clear; start decides on this value
  // so a coincident write is included in the playback.
  assign w_cnt_idle = clear   ? '0 :
                      w_wr_ok ? (r_count + CW'(1)) : r_count;

  range_sample_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_buf (
    .clock (clock),
    .we    (w_wr_ok),
    .waddr (r_count[PW-1:0]),
    .wdata (wr_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_data_out <= '0;
      r_go       <= 1'b0;
      r_finish   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
      r_flush_q  <= 1'b0;
    end else begin
      r_go     <= 1'b0;
      r_finish <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy    <= 1'b0;
          r_done    <= r_flush_q;
          r_flush_q <= 1'b0;
          r_count   <= w_cnt_idle;
          if (clear) begin
            r_overflow <= 1'b0;
          end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
          end
          if (start) begin
            if (w_cnt_idle == '0) begin
              r_error <= 1'b1;
            end else begin
              r_state  <= PLAY;
              r_rd_ptr <= '0;
            end
          end
        end
        PLAY: begin
          r_busy     <= 1'b1;
          r_data_out <= w_rdata;
          r_go       <= (r_rd_ptr == '0);
          r_finish   <= w_last;
          if (w_last) begin
            r_state <= FLUSH;
          end else begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
          end
        end
        FLUSH: begin
          // Settle cycle: data_out holds the last sample.
          r_busy    <= 1'b1;
          r_flush_q <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign data_out = r_data_out;
  assign go       = r_go;
  assign finish   = r_finish;
  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign error    = r_error;

`ifdef RANGE_EXPECT_EN
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;
  logic             r_mismatch;
  logic [WIDTH-1:0] w_exp_range;

  // With a single sample min==max, so the expected range is 0.
  assign w_exp_range = r_max - r_min;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_min      <= '1;
      r_max      <= '0;
      r_mismatch <= 1'b0;
    end else if ((r_state == IDLE) && clear) begin
      r_min      <= '1;
      r_max      <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        if (wr_data < r_min) r_min <= wr_data;
        if (wr_data > r_max) r_max <= wr_data;
      end
      if ((r_state == FLUSH) && (range_in != w_exp_range)) begin
        r_mismatch <= 1'b1;
      end
    end
  end

  assign mismatch = r_mismatch;
`else
  logic w_unused_range;
  assign w_unused_range = ^range_in;
  assign mismatch       = 1'b0;
`endif

endmodule

// File: tb/tb_range_stream_gen.sv
module tb_range_stream_gen;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam int OP_IDLE  = 0;
  localparam int OP_WR    = 1;
  localparam int OP_CLR   = 2;
  localparam int OP_START = 3;
  localparam int OP_WRCLR = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             clear;
  logic             start;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             busy;
  logic             done;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             error;
  logic [WIDTH-1:0] range_in;
  logic             mismatch;

  always #5 clock = ~clock;

  range_stream_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clear    (clear),
    .start    (start),
    .data_out (data_out),
    .go       (go),
    .finish   (finish),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .overflow (overflow),
    .error    (error),
    .range_in (range_in),
    .mismatch (mismatch)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the list of held samples plus sticky flags.
  logic [WIDTH-1:0] q[$];
  bit               ov_m;
  bit               mm_m;

  typedef struct {
    int               op;
    logic [WIDTH-1:0] data;
    int               ecount;
    bit               eov;
    bit               eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_range();
    logic [WIDTH-1:0] mn, mx;
    mn = '1;
    mx = '0;
    foreach (q[i]) begin
      if (q[i] < mn) mn = q[i];
      if (q[i] > mx) mx = q[i];
    end
    return mx - mn;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic wr(input logic [WIDTH-1:0] v);
    wr_en = 1'b1;
    wr_data = v;
    @(negedge clock);
    wr_en = 1'b0;
    if (q.size() < DEPTH) q.push_back(v);
    else ov_m = 1'b1;
    $display("write %02h -> count %0d overflow %0d", v, count, overflow);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    q.delete();
    ov_m = 1'b0;
    mm_m = 1'b0;
    check("clear_count", count, 0);
    check("clear_overflow", overflow, 0);
  endtask

  // Pulse start (optionally with a coincident write) and check the whole
  // frame: n samples, one settle cycle, then done.
  task automatic play(input logic [WIDTH-1:0] rng, input bit coincide, input logic [WIDTH-1:0] wv);
    int n;
    range_in = rng;
    start = 1'b1;
    if (coincide) begin
      wr_en = 1'b1;
      wr_data = wv;
      if (q.size() < DEPTH) q.push_back(wv);
      else ov_m = 1'b1;
    end
    n = q.size();
    @(negedge clock);
    start = 1'b0;
    wr_en = 1'b0;
    check("start_busy", busy, 0);
    check("start_error", error, 0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      check($sformatf("data[%0d]", k), data_out, q[k-1]);
      check($sformatf("go[%0d]", k), go, (k == 1));
      check($sformatf("finish[%0d]", k), finish, (k == n));
      check($sformatf("busy[%0d]", k), busy, 1);
      check($sformatf("done[%0d]", k), done, 0);
    end
    @(negedge clock);
    check("flush_busy", busy, 1);
    check("flush_go", go, 0);
    check("flush_finish", finish, 0);
    check("flush_data", data_out, q[n-1]);
    check("flush_done", done, 0);
`ifdef RANGE_EXPECT_EN
    if (rng != model_range()) mm_m = 1'b1;
`endif
    @(negedge clock);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_count", count, n);
    check("done_mismatch", mismatch, mm_m);
    @(negedge clock);
    check("done_clear", done, 0);
    $display("play n=%0d range_in=%02h mismatch=%0d", n, rng, mismatch);
  endtask

  task automatic empty_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("empty_error", error, 1);
    check("empty_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("empty_error_drop", error, 0);
      check("empty_go", go, 0);
      check("empty_busy_idle", busy, 0);
    end
    $display("start on empty buffer");
  endtask

  initial begin
    logic [WIDTH-1:0] seq[4];
    int nw;

    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    clear = 1'b0;
    start = 1'b0;
    range_in = '0;
    ov_m = 1'b0;
    mm_m = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_data", data_out, 0);
    check("rst_go", go, 0);
    check("rst_finish", finish, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_error", error, 0);
    check("rst_mismatch", mismatch, 0);
    reset = 1'b0;
    @(negedge clock);

    // ---------------- table-driven IDLE behaviour ----------------
    vecs.push_back('{OP_IDLE,  8'h00, 0, 0, 0});
    vecs.push_back('{OP_START, 8'h00, 0, 0, 1});
    vecs.push_back('{OP_IDLE,  8'h00, 0, 0, 0});
    for (int i = 1; i <= DEPTH; i++) vecs.push_back('{OP_WR, 8'(i * 17), i, 0, 0});
    vecs.push_back('{OP_WR,    8'hEE, DEPTH, 1, 0});
    vecs.push_back('{OP_IDLE,  8'h00, DEPTH, 1, 0});
    vecs.push_back('{OP_CLR,   8'h00, 0, 0, 0});
    vecs.push_back('{OP_WRCLR, 8'h44, 0, 0, 0});
    vecs.push_back('{OP_WR,    8'h44, 1, 0, 0});
    vecs.push_back('{OP_CLR,   8'h00, 0, 0, 0});
    foreach (vecs[i]) begin
      wr_en   = (vecs[i].op == OP_WR) || (vecs[i].op == OP_WRCLR);
      clear   = (vecs[i].op == OP_CLR) || (vecs[i].op == OP_WRCLR);
      start   = (vecs[i].op == OP_START);
      wr_data = vecs[i].data;
      @(negedge clock);
      wr_en = 1'b0;
      clear = 1'b0;
      start = 1'b0;
      check($sformatf("vec%0d_count", i), count, vecs[i].ecount);
      check($sformatf("vec%0d_overflow", i), overflow, vecs[i].eov);
      check($sformatf("vec%0d_error", i), error, vecs[i].eerr);
      check($sformatf("vec%0d_busy", i), busy, 0);
      check($sformatf("vec%0d_go", i), go, 0);
      $display("vec %0d op %0d data %02h -> count %0d ov %0d err %0d",
               i, vecs[i].op, vecs[i].data, count, overflow, error);
    end
    do_clear();

    // ---------------- basic 4-sample frame and replay ----------------
    seq[0] = 8'd3; seq[1] = 8'd9; seq[2] = 8'd1; seq[3] = 8'd7;
    foreach (seq[i]) wr(seq[i]);
    play(model_range(), 1'b0, '0);
    play(model_range(), 1'b0, '0);

    // ---------------- single sample ----------------
    do_clear();
    wr(8'h55);
    play(8'h00, 1'b0, '0);

    // ---------------- overflow: 9th sample never plays ----------------
    do_clear();
    for (int i = 0; i < DEPTH + 1; i++) wr(8'(8'hA0 + i));
    check("ovf_count", count, DEPTH);
    check("ovf_flag", overflow, 1);
    play(model_range(), 1'b0, '0);
    check("ovf_sticky", overflow, 1);
    do_clear();

    // ---------------- empty start ----------------
    empty_start();

    // ---------------- start coinciding with a write ----------------
    wr(8'h21);
    wr(8'h22);
    play(model_range(), 1'b1, 8'h23);

    // ---------------- reset during playback ----------------
    do_clear();
    for (int i = 0; i < DEPTH; i++) wr(8'($urandom_range(0, 255)));
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check($sformatf("rstplay_data[%0d]", k), data_out, q[k-1]);
      check($sformatf("rstplay_go[%0d]", k), go, (k == 1));
    end
    reset = 1'b1;
    #1;
    check("midrst_go", go, 0);
    check("midrst_finish", finish, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", data_out, 0);
    check("midrst_count", count, 0);
    q.delete();
    ov_m = 1'b0;
    mm_m = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      @(negedge clock);
      check("midrst_no_done", done, 0);
      check("midrst_idle", busy, 0);
    end
    $display("reset during playback");
    empty_start();

    // ---------------- expected-range check ----------------
    wr(8'd10);
    wr(8'd200);
    wr(8'd50);
    play(8'd190, 1'b0, '0);
    play(8'd189, 1'b0, '0);
    @(negedge clock);
    check("mm_sticky", mismatch, mm_m);
    do_clear();
    check("mm_cleared", mismatch, 0);

    // ---------------- randomized frames against the model ----------------
    for (int r = 0; r < 8; r++) begin
      do_clear();
      nw = $urandom_range(1, DEPTH + 3);
      for (int i = 0; i < nw; i++) wr(8'($urandom_range(0, 255)));
      check($sformatf("rnd%0d_count", r), count, q.size());
      check($sformatf("rnd%0d_overflow", r), overflow, ov_m);
      play(model_range() + 8'($urandom_range(0, 1)), 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
